// File: rtl/uart_tx_port_if.sv
// Bus-side connection for the memory-mapped UART transmit port.
interface uart_tx_port_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output we, output addr, output wdata, input rdata, input hit);
  modport slave  (input we, input addr, input wdata, output rdata, output hit);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: DATA/STATUS registers, small TX FIFO, 8N1 serialiser.
module uart_tx_port #(
  parameter logic [31:0] BASE_ADDR    = 32'h804,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_port_if.slave  bus,
  output logic           o_tx,
  output logic           o_busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  // Serialiser state
  state_t           r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_sr;
  logic             r_tx;

  state_t            w_state_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        w_bit_nxt;
  logic [7:0]        w_sr_nxt;
  logic              w_tx_nxt;
  logic              w_pop;

  logic w_hit_data;
  logic w_hit_status;
  logic w_push;
  logic w_push_ok;
  logic w_full;
  logic w_empty;
  logic w_tx_active;
  logic w_baud_done;
  logic w_ovf_set;
  logic w_ovf_clr;
  logic [31:0] w_status;
  logic w_unused;

  // Address decode and FIFO flow control
  assign w_hit_data   = (bus.addr == BASE_ADDR);
  assign w_hit_status = (bus.addr == STATUS_ADDR);
  assign w_push       = bus.we && w_hit_data;
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push_ok    = w_push && (!w_full || w_pop);
  assign w_ovf_set    = w_push && !w_push_ok;
  assign w_ovf_clr    = bus.we && w_hit_status && bus.wdata[3];
  assign w_tx_active  = (r_state != S_IDLE);
  assign w_baud_done  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_unused     = ^bus.wdata[31:8];

  // Combinational register read; DATA reads as zero
  assign w_status  = {24'd0, 4'(r_count), r_ovf, w_tx_active, w_empty, w_full};
  assign bus.hit   = w_hit_data || w_hit_status;
  assign bus.rdata = w_hit_status ? w_status : 32'd0;

  assign o_tx   = r_tx;
  assign o_busy = !w_empty || w_tx_active;

  // FIFO data array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Serialiser state register; tx forced high asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_sr    <= w_sr_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state logic; tx is computed from the next state so it is registered
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_sr_nxt    = r_sr;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_sr_nxt    = r_mem[r_rd_ptr];
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          w_sr_nxt   = {1'b0, r_sr[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_sr_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with a serial-line receiver feeding a byte scoreboard.
module tb_uart_tx_port;

  localparam int CPB = 4;
  localparam logic [31:0] A_DATA = 32'h804;
  localparam logic [31:0] A_STAT = 32'h808;

  logic clk;
  logic reset;
  logic tx;
  logic busy;

  uart_tx_port_if bus ();

  uart_tx_port #(
    .BASE_ADDR    (32'h804),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .o_tx   (tx),
    .o_busy (busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_frames = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  // Receiver state
  int         m_j = -1;
  int         m_b;
  int         m_k;
  logic       m_ok;
  logic [7:0] m_byte;
  logic [7:0] m_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver: samples every bit cycle of a frame, scoreboards the byte
  always @(negedge clk) begin
    if (reset) begin
      m_j = -1;
    end else begin
      if (m_j < 0 && tx === 1'b0) begin
        m_j    = 0;
        m_ok   = 1'b1;
        m_byte = 8'h00;
        start_q.push_back(cyc);
      end
      if (m_j >= 0) begin
        m_b = m_j / CPB;
        m_k = m_j % CPB;
        if (m_b == 0) begin
          if (tx !== 1'b0) m_ok = 1'b0;
        end else if (m_b == 9) begin
          if (tx !== 1'b1) m_ok = 1'b0;
        end else if (m_k == 0) begin
          m_byte[m_b-1] = tx;
        end else if (tx !== m_byte[m_b-1]) begin
          m_ok = 1'b0;
        end
        m_j++;
        if (m_j == 10 * CPB) begin
          m_j = -1;
          n_frames++;
          check("frame_shape", 32'(m_ok), 32'd1);
          n_checks++;
          assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL frame_unexpected: observed=%0h expected=none", m_byte);
          end
          if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            check("frame_byte", 32'(m_byte), 32'(m_exp));
          end
        end
      end
    end
  end

  // One bus write occupying exactly one clock edge; call at a negedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.rdata;
    h = bus.hit;
    bus.addr = 32'd0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (n_frames < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frames_done", 32'(n_frames), 32'(target));
  endtask

  logic [31:0] rv;
  logic        rh;
  int          wcyc;
  int          s1;
  int          s2;
  int          base;

  initial begin
    reset     = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rd(A_STAT, rv, rh);
    check("rst_status", rv, 32'h02);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-frame aborts and forces tx high without a clock edge
    wr(A_DATA, 32'h00);
    repeat (8) @(negedge clk);
    check("midframe_tx_low", 32'(tx), 32'd0);
    check("midframe_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rd(A_STAT, rv, rh);
    check("rst_hold_status", rv, 32'h02);
    reset = 1'b0;
    @(negedge clk);
    rd(A_STAT, rv, rh);
    check("post_rst_status", rv, 32'h02);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    start_q.delete();
    base = n_frames;

    // Single frame, upper write bits ignored
    exp_q.push_back(8'hA5);
    wr(A_DATA, 32'h1A5);
    wcyc = cyc;
    rd(A_STAT, rv, rh);
    check("t2_status_queued", rv, 32'h10);
    check("t2_tx_idle_at_write", 32'(tx), 32'd1);
    @(negedge clk);
    check("t2_start_low", 32'(tx), 32'd0);
    rd(A_STAT, rv, rh);
    check("t2_status_active", rv, 32'h06);
    while (cyc < wcyc + 40) @(negedge clk);
    check("t2_busy_in_stop", 32'(busy), 32'd1);
    @(negedge clk);
    check("t2_busy_done", 32'(busy), 32'd0);
    check("t2_tx_idle", 32'(tx), 32'd1);
    wait_frames(base + 1, 20);
    s1 = (start_q.size() != 0) ? start_q.pop_front() : -1;
    check("t2_start_cycle", 32'(s1), 32'(wcyc + 1));
    base = n_frames;
    repeat (2) @(negedge clk);

    // Back-to-back frames with one idle cycle between them
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    wr(A_DATA, 32'h55);
    wcyc = cyc;
    wr(A_DATA, 32'h0F);
    rd(A_STAT, rv, rh);
    check("t3_status_count1", rv, 32'h14);
    wait_frames(base + 2, 2 * 10 * CPB + 40);
    s1 = (start_q.size() != 0) ? start_q.pop_front() : -1;
    s2 = (start_q.size() != 0) ? start_q.pop_front() : -1;
    check("t3_start1", 32'(s1), 32'(wcyc + 1));
    check("t3_frame_gap", 32'(s2 - s1), 32'(10 * CPB + 1));
    base = n_frames;
    repeat (2) @(negedge clk);

    // Overflow: six consecutive writes, last one dropped
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) wr(A_DATA, 32'(i));
    rd(A_STAT, rv, rh);
    check("t4_status_full_ovf", rv, 32'h4D);
    check("t4_busy", 32'(busy), 32'd1);
    wait_frames(base + 5, 5 * (10 * CPB + 1) + 40);
    repeat (2) @(negedge clk);
    rd(A_STAT, rv, rh);
    check("t4_status_drained", rv, 32'h0A);
    start_q.delete();
    base = n_frames;

    // Overflow clear only via wdata[3]
    wr(A_STAT, 32'h00);
    rd(A_STAT, rv, rh);
    check("t5_no_clear_zero", rv, 32'h0A);
    wr(A_STAT, 32'hFFFF_FFF7);
    rd(A_STAT, rv, rh);
    check("t5_no_clear_other", rv, 32'h0A);
    wr(A_STAT, 32'h08);
    rd(A_STAT, rv, rh);
    check("t5_cleared", rv, 32'h02);

    // Address decode
    rd(32'h800, rv, rh);
    check("t6_800_hit", 32'(rh), 32'd0);
    check("t6_800_rdata", rv, 32'd0);
    rd(32'h80C, rv, rh);
    check("t6_80c_hit", 32'(rh), 32'd0);
    check("t6_80c_rdata", rv, 32'd0);
    rd(A_DATA, rv, rh);
    check("t6_data_hit", 32'(rh), 32'd1);
    check("t6_data_rdata", rv, 32'd0);
    wr(32'h800, 32'h77);
    wr(32'h80C, 32'h77);
    rd(A_STAT, rv, rh);
    check("t6_stat_hit", 32'(rh), 32'd1);
    check("t6_no_push", rv, 32'h02);
    repeat (2 * 10 * CPB) @(negedge clk);
    check("t6_no_frames", 32'(n_frames), 32'(base));
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
